imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit words in the target instruction memory (max legal load length).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle pulse; begins a load session when in IDLE, DONE or ERROR.
REQ-005 Port: byte_valid  input  1  source has a byte on byte_data.
REQ-006 Port: byte_data  input  8  stream byte.
REQ-007 Port: byte_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: we  output  1  write strobe to instruction RAM.
REQ-009 Port: wa  output  32  byte address of write; word index in wa[31:2], wa[1:0]=2'b00.
REQ-010 Port: wd  output  32  assembled write word.
REQ-011 Port: cpu_reset  output  1  holds the processor in reset while loading.
REQ-012 Port: done  output  1  load completed successfully.
REQ-013 Port: error  output  1  load aborted (bad length or checksum).

Function
REQ-014 States SHALL be IDLE, LEN, BYTES, WRITE, CHK, DONE, ERROR.
REQ-015 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in LEN, BYTES and CHK.
REQ-016 start in IDLE/DONE/ERROR SHALL enter LEN next cycle and clear done, error, word index and byte index; start in any other state SHALL be ignored.
REQ-017 LEN: accepted byte is word count N; N=0 or N>DEPTH -> ERROR; else latch N, go to BYTES.
REQ-018 BYTES: bytes SHALL be assembled little-endian (1st byte -> wd[7:0], 4th -> wd[31:24]); on the 4th accepted byte go to WRITE.
REQ-019 WRITE: we=1 for exactly one cycle with wa={word_index,2'b00} and the assembled wd; word_index then increments; if it reached N go to CHK (macro on) or DONE (macro off), else BYTES.
REQ-020 we SHALL be 0 in every state except WRITE; wd and wa SHALL hold their last value otherwise.
REQ-021 Word latency: WRITE SHALL occur the cycle after the 4th byte handshake; with byte_valid held high, throughput is one word per 5 cycles.
REQ-022 Word index SHALL never wrap; last write address is 4*(N-1).
REQ-023 cpu_reset SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE; error only in ERROR.
REQ-024 DONE and ERROR SHALL be held until reset or start.
REQ-025 byte_valid with byte_ready=0 SHALL be ignored with no data consumed.

Reset
REQ-026 reset SHALL force IDLE, we=0, wa=0, wd=0, byte_ready=0, cpu_reset=1, done=0, error=0, indices and checksum=0.
REQ-027 reset asserted mid-load SHALL abort the session on the next edge; no further we pulses; already-written words are not undone.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of all data bytes (not the length byte) kept; CHK accepts one byte, equal -> DONE, else ERROR.
REQ-029 Macro undefined: CHK state, checksum register and compare logic SHALL be absent; last WRITE goes directly to DONE.

Structure
REQ-030 Shared package imem_loader_pkg SHALL hold the state enumeration and the word/byte width constants (32, 8, bytes-per-word 4).
REQ-031 One sub-module, imem_word_asm (byte-lane shift register plus 2-bit byte counter, emits word_full), is natural; FSM and counters stay in imem_loader.

Verification
REQ-032 Load N=2, bytes 78 56 34 12 EF BE AD DE, valid always high -> we at wa=0 wd=32'h12345678, then wa=4 wd=32'hDEADBEEF, done=1, cpu_reset=0.
REQ-033 Length byte 0x00, then separately 0x41 with DEPTH=64 -> ERROR, error=1, no we pulse, cpu_reset=1.
REQ-034 N=1 with byte_valid toggled 1/0 each cycle -> exactly four bytes consumed, single we with wd=32'h04030201 for bytes 01 02 03 04.
REQ-035 reset pulsed after 2nd data byte of N=1 -> IDLE next cycle, no we, all outputs at reset values; subsequent start + full load succeeds.
REQ-036 Macro on, N=1 bytes 01 02 04 08, checksum 0x0F -> done=1; checksum 0x0E -> error=1 after the word is written.
REQ-037 start asserted during BYTES -> ignored, load completes normally with same addresses.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state used for the trailing checksum byte.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTES,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian byte-lane shift register: the first byte of a word ends up in [7:0].
// word_next is the word as it will look after the current byte is shifted in.
module imem_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_full
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;

    assign word_next = {byte_in, word_q[WORD_W-1:BYTE_W]};
    assign word_full = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = word_next;
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction RAM while holding the CPU in reset.
// Build option: IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte checked in CHK.
//
// state   | meaning
// IDLE    | waiting for start, CPU held in reset
// LEN     | accept word-count byte
// BYTES   | accept four data bytes of the current word
// WRITE   | one-cycle write strobe to instruction RAM
// CHK     | accept and compare checksum byte (checksum build only)
// DONE    | image loaded, CPU released
// ERROR   | bad length or checksum, CPU held in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [WORD_W-1:0] wa,
    output logic [WORD_W-1:0] wd,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [BYTE_W:0] DEPTH_LIM = (BYTE_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] len_q, len_d;
    logic [BYTE_W-1:0] word_idx_q, word_idx_d;
    logic [WORD_W-1:0] wa_q, wa_d, wd_q, wd_d;
    logic              byte_ready_q, byte_ready_d;
    logic              we_q, we_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hs, asm_clear, asm_shift, asm_full;
    logic [WORD_W-1:0] asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_q, chk_d;
`endif

    assign hs = byte_valid && byte_ready_q;

    imem_word_asm u_word_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (byte_data),
        .word_next (asm_word),
        .word_full (asm_full)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        asm_clear  = 1'b0;
        asm_shift  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN;
                    word_idx_d = '0;
                    asm_clear  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_LEN: begin
                if (hs) begin
                    if (byte_data == '0 || {1'b0, byte_data} > DEPTH_LIM) begin
                        state_d = S_ERROR;
                    end else begin
                        len_d   = byte_data;
                        state_d = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                asm_shift = hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (hs) chk_d = chk_q ^ byte_data;
`endif
                // Capture the word on the 4th handshake so WRITE presents it immediately
                if (asm_full) begin
                    wd_d    = asm_word;
                    wa_d    = WORD_W'({word_idx_q, 2'b00});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                if (word_idx_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_BYTES;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (hs) state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered
        byte_ready_d = (state_d == S_LEN) || (state_d == S_BYTES)
`ifdef IMEM_LOADER_CHECKSUM_EN
                       || (state_d == S_CHK)
`endif
                       ;
        we_d        = (state_d == S_WRITE);
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            wa_q         <= '0;
            wd_q         <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign we         = we_q;
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of load sessions plus hand-written
// reset-abort, start-while-busy and (checksum build) bad-checksum sequences.
module tb_imem_loader;

    localparam int DEPTH = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, we, cpu_reset, done, error;
    logic [31:0] wa, wd;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wr_wa[$];
    logic [31:0] wr_wd[$];
    int          wr_cyc[$];
    int          hs_cyc[$];

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_wa.push_back(wa);
            wr_wd.push_back(wd);
            wr_cyc.push_back(cyc);
        end
        if (byte_valid === 1'b1 && byte_ready === 1'b1) hs_cyc.push_back(cyc);
    end

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  len;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_err;
        bit          toggle;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    function automatic logic [31:0] exp_word(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.w0 ^ (32'(i) * 32'h0001_0001);
    endfunction

    task automatic clear_logs();
        wr_wa.delete();
        wr_wd.delete();
        wr_cyc.delete();
        hs_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (byte_ready === 1'b1);
        if (!ok) timeout_fail("byte_handshake");
        @(posedge clk); #1;
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1 && error !== 1'b1) timeout_fail("wait_done_or_error");
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] w;
        logic [7:0]  cs;
        bit          ok;
        int          n_exp;
        clear_logs();
        cs = 8'h00;
        ok = 1'b1;
        pulse_start();
        send_byte(v.len, ok);
        n_exp = v.exp_err ? 0 : int'(v.len);
        for (int i = 0; i < n_exp && ok; i++) begin
            w = exp_word(v, i);
            for (int b = 0; b < 4 && ok; b++) begin
                send_byte(w[8*b +: 8], ok);
                cs = cs ^ w[8*b +: 8];
                if (v.toggle) begin
                    byte_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ok && !v.exp_err) send_byte(cs, ok);
`endif
        byte_valid = 1'b0;
        wait_end();
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".done"},       32'(done),       32'(!v.exp_err));
        check({tag, ".error"},      32'(error),      32'(v.exp_err));
        check({tag, ".cpu_reset"},  32'(cpu_reset),  32'(v.exp_err));
        check({tag, ".byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, ".we_idle"},    32'(we),         32'd0);
        check({tag, ".n_writes"},   32'(wr_wa.size()), 32'(n_exp));
        check({tag, ".n_bytes"},    32'(hs_cyc.size()), v.exp_err ? 32'd1 : 32'(1 + 4 * n_exp + CK));
        for (int k = 0; k < n_exp && k < wr_wa.size(); k++) begin
            check($sformatf("%s.wa[%0d]", tag, k), wr_wa[k], 32'(4 * k));
            check($sformatf("%s.wd[%0d]", tag, k), wr_wd[k], exp_word(v, k));
        end
        if (n_exp > 0 && wr_cyc.size() > 0 && hs_cyc.size() > 4)
            check({tag, ".latency"}, 32'(wr_cyc[0] - hs_cyc[4]), 32'd1);
        if (!v.toggle && n_exp >= 2 && wr_cyc.size() >= 2)
            check({tag, ".throughput"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
    endtask

    initial begin
        bit          ok;
        logic [7:0]  cs;
        logic [7:0]  img[8];

        vecs[0] = '{len: 8'd2,    w0: 32'h1234_5678, w1: 32'hDEAD_BEEF, exp_err: 1'b0, toggle: 1'b0};
        vecs[1] = '{len: 8'h00,   w0: 32'h0,         w1: 32'h0,         exp_err: 1'b1, toggle: 1'b0};
        vecs[2] = '{len: 8'h41,   w0: 32'h0,         w1: 32'h0,         exp_err: 1'b1, toggle: 1'b0};
        vecs[3] = '{len: 8'd1,    w0: 32'h0403_0201, w1: 32'h0,         exp_err: 1'b0, toggle: 1'b1};
        vecs[4] = '{len: 8'd1,    w0: 32'h0804_0201, w1: 32'h0,         exp_err: 1'b0, toggle: 1'b0};
        vecs[5] = '{len: 8'd64,   w0: 32'hCAFE_0000, w1: 32'h0BAD_F00D, exp_err: 1'b0, toggle: 1'b0};
        vecs[6] = '{len: 8'hFF,   w0: 32'h0,         w1: 32'h0,         exp_err: 1'b1, toggle: 1'b0};
        vecs[7] = '{len: 8'd3,    w0: 32'h1122_3344, w1: 32'h5566_7788, exp_err: 1'b0, toggle: 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.we",         32'(we),         32'd0);
        check("rst.wa",         wa,              32'd0);
        check("rst.wd",         wd,              32'd0);
        check("rst.byte_ready", 32'(byte_ready), 32'd0);
        check("rst.cpu_reset",  32'(cpu_reset),  32'd1);
        check("rst.done",       32'(done),       32'd0);
        check("rst.error",      32'(error),      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset after the 2nd data byte of an N=1 load
        clear_logs();
        pulse_start();
        send_byte(8'd1, ok);
        send_byte(8'hA1, ok);
        send_byte(8'hA2, ok);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid.we",         32'(we),         32'd0);
        check("rstmid.wa",         wa,              32'd0);
        check("rstmid.wd",         wd,              32'd0);
        check("rstmid.byte_ready", 32'(byte_ready), 32'd0);
        check("rstmid.cpu_reset",  32'(cpu_reset),  32'd1);
        check("rstmid.done",       32'(done),       32'd0);
        check("rstmid.error",      32'(error),      32'd0);
        reset = 1'b0;
        clear_logs();
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("rstmid.idle_no_bytes", 32'(hs_cyc.size()), 32'd0);
        check("rstmid.no_we",         32'(wr_wa.size()),  32'd0);
        run_vec(vecs[0], "after_rst");

        // start pulse while in BYTES must be ignored
        clear_logs();
        img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cs = 8'h00;
        pulse_start();
        send_byte(8'd2, ok);
        for (int b = 0; b < 2; b++) begin
            send_byte(img[b], ok);
            cs = cs ^ img[b];
        end
        byte_valid = 1'b0;
        pulse_start();
        for (int b = 2; b < 8; b++) begin
            send_byte(img[b], ok);
            cs = cs ^ img[b];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, ok);
`endif
        byte_valid = 1'b0;
        wait_end();
        check("busy_start.done",     32'(done),          32'd1);
        check("busy_start.n_writes", 32'(wr_wa.size()),  32'd2);
        if (wr_wa.size() == 2) begin
            check("busy_start.wa0", wr_wa[0], 32'h0000_0000);
            check("busy_start.wd0", wr_wd[0], 32'h1234_5678);
            check("busy_start.wa1", wr_wa[1], 32'h0000_0004);
            check("busy_start.wd1", wr_wd[1], 32'hDEAD_BEEF);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // wrong checksum: word still written, then ERROR
        clear_logs();
        pulse_start();
        send_byte(8'd1, ok);
        send_byte(8'h01, ok);
        send_byte(8'h02, ok);
        send_byte(8'h04, ok);
        send_byte(8'h08, ok);
        send_byte(8'h0E, ok);
        byte_valid = 1'b0;
        wait_end();
        check("badck.error",     32'(error),         32'd1);
        check("badck.done",      32'(done),          32'd0);
        check("badck.cpu_reset", 32'(cpu_reset),     32'd1);
        check("badck.n_writes",  32'(wr_wa.size()),  32'd1);
        if (wr_wd.size() == 1) check("badck.wd0", wr_wd[0], 32'h0804_0201);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
